ovl_win_chk_arbiter: RTL and testbench
======================================

// Module: ovl_win_chk_arbiter
// PURPOSE
//  Shares one ovl_win_unchange checker among NUM_REQ requesters. Grants one window at a
//  time, round-robin. Per window: one-cycle start_event pulse, then win_len cycles open,
//  then one-cycle end_event pulse, while muxing the winner's expression onto test_expr.
//  Sits between stimulus agents and the checker instance in the OVL test benches.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2)
//  WIDTH    4  test_expr width; must match the checker's width
//  CNT_W    8  width of each window-length field
//  MIN_GAP  1  idle cycles enforced after end_event before the next grant (0 allowed)
// PORTS
//  clock      in   1               clock, all state on posedge
//  reset      in   1               asynchronous, active-high reset
//  enable     in   1               allows new grants; an open window always completes
//  req        in   NUM_REQ         level request per requester; hold until done[i]
//  win_len    in   NUM_REQ*CNT_W   window length of requester i = slice i; sampled at grant
//  req_expr   in   NUM_REQ*WIDTH   expression of requester i = slice i
//  grant      out  NUM_REQ         one-hot owner of the checker; 0 when no window active
//  done       out  NUM_REQ         one-cycle pulse to owner in the END cycle
//  start_event out 1               to checker start_event
//  end_event  out  1               to checker end_event
//  test_expr  out  WIDTH           to checker test_expr
//  busy       out  1               high in START/OPEN/END/GAP
//  xz_err     out  1               one-cycle pulse: X/Z on req or on enable while IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer 0; counter 0. Reset asserted mid-window
//   drops start/end/grant at once; no end_event is issued for the aborted window.
//  FSM (registered outputs, one state per cycle):
//   IDLE : enable=1 & |req -> pick first set req at or above ptr (wraps); latch index g;
//          grant<=onehot(g); cnt<=max(win_len[g],1) -> START. Else stay.
//          $isunknown(req|enable) -> xz_err=1, no grant, stay IDLE.
//   START: start_event=1 -> OPEN.
//   OPEN : cnt decrements each cycle; cnt==1 -> END. OPEN lasts exactly L cycles.
//   END  : end_event=1, done[g]=1; ptr<=(g+1) mod NUM_REQ; grant cleared on exit;
//          -> GAP if MIN_GAP>0 else IDLE.
//   GAP  : MIN_GAP cycles, grant=0, test_expr=0 -> IDLE.
//  Timing: start_event at cycle t, end_event at t+L+1; first request seen in IDLE at
//   t0 gives start_event at t0+2 (grant at t0+1).
//  test_expr = req_expr slice g while grant!=0 (START..END inclusive), else 0; combinational
//   from registered g, no added latency.
//  win_len=0 treated as 1. win_len and req sampled only in IDLE; changes later are ignored.
//  req withdrawn mid-window: window still runs to END; done still pulses.
//  enable low mid-window: no effect until back in IDLE.
//  Back-to-back: with MIN_GAP=0, the next start_event comes 2 cycles after end_event
//   (END->IDLE->START). start_event and end_event are never high together.
// STRUCTURE
//  Package ovl_win_arb_pkg: state_e {IDLE,START,OPEN,END,GAP}; default CNT_W; helper
//   function onehot(idx).
//  Sub-module ovl_rr_pick #(N): combinational round-robin picker (req, ptr -> valid, idx).
//  Top holds FSM, window/gap counter, ptr, g register, expression mux.
// TESTING
//  1 Single req[1], win_len=3, expr=4'h5 -> grant=4'b0010; start at t0+2, end at t0+6;
//    test_expr=5 throughout; checker does not fire.
//  2 req=4'b1111 held, all win_len=2 -> grants in order 0,1,2,3,0; each window 3-cycle
//    start->end; MIN_GAP=1 idle cycle between windows.
//  3 Owner changes its expr 4'h1->4'h2 inside its window -> checker fires; arbiter
//    ordering unaffected.
//  4 win_len=0 -> window open 1 cycle; end_event exactly 2 cycles after start_event.
//  5 Reset asserted 2 cycles into OPEN -> grant/start/end 0 at once; after release,
//    pending req[0] is granted first (ptr=0).
//  6 req=4'b00X1 in IDLE -> xz_err pulse, no grant; enable=0 with req set -> no grant.

Source files
------------

// File: rtl/ovl_win_chk_arbiter_pkg.sv
// Shared types and helpers for the OVL window-checker arbiter.
package ovl_win_arb_pkg;

   typedef enum logic [2:0] {IDLE, START, OPEN, END, GAP} state_e;

   localparam int DEF_CNT_W = 8;
   localparam int MAX_REQ   = 32;

   function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
      return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/ovl_win_chk_arbiter_if.sv
// Bundle between stimulus agents (master) and the window arbiter (slave).
interface ovl_win_chk_arbiter_if
   import ovl_win_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int CNT_W   = DEF_CNT_W
);
   logic                     enable;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*CNT_W-1:0] win_len;
   logic [NUM_REQ*WIDTH-1:0] req_expr;
   logic [NUM_REQ-1:0]       grant;
   logic [NUM_REQ-1:0]       done;
   logic                     start_event;
   logic                     end_event;
   logic [WIDTH-1:0]         test_expr;
   logic                     busy;
   logic                     xz_err;

   modport master (
      output enable, req, win_len, req_expr,
      input  grant, done, start_event, end_event, test_expr, busy, xz_err
   );

   modport slave (
      input  enable, req, win_len, req_expr,
      output grant, done, start_event, end_event, test_expr, busy, xz_err
   );
endinterface

// File: rtl/ovl_win_chk_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module ovl_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 valid,
   output logic [$clog2(N)-1:0] idx
);
   localparam int IW = $clog2(N);

   logic [N-1:0] rot;
   int           off;
   int           sum;

   // Rotate so that bit 0 is the requester at ptr; lowest set bit then wins.
   always_comb begin
      rot   = N'({req, req} >> ptr);
      valid = 1'b0;
      off   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            valid = 1'b1;
            off   = k;
         end
      end
      sum = int'(ptr) + off;
      if (sum >= N) sum = sum - N;
      idx = IW'(sum);
   end
endmodule

// File: rtl/ovl_win_chk_arbiter.sv
// Time-shares one ovl_win_unchange checker among NUM_REQ requesters, round-robin,
// generating start/end pulses and muxing the owner's expression onto test_expr.
module ovl_win_chk_arbiter
   import ovl_win_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int CNT_W   = DEF_CNT_W,
   parameter int MIN_GAP = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   ovl_win_chk_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);

   state_e             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IW-1:0]      ptr, ptr_nxt;
   logic [IW-1:0]      g, g_nxt;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               start_q, start_d;
   logic               end_q, end_d;
   logic               xz_q, xz_d;
   logic               pick_vld;
   logic [IW-1:0]      pick_idx;
   logic               in_xz;
   logic               accept;
   logic [CNT_W-1:0]   len_sel;

   ovl_rr_pick #(.N(NUM_REQ)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // Unknown inputs block any grant so a broken agent cannot own the checker.
   assign in_xz   = $isunknown({bus.req, bus.enable});
   assign accept  = bus.enable & pick_vld & ~in_xz;
   assign len_sel = bus.win_len[pick_idx*CNT_W +: CNT_W];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         ptr     <= '0;
         g       <= '0;
         grant_q <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
         xz_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ptr     <= ptr_nxt;
         g       <= g_nxt;
         grant_q <= grant_d;
         done_q  <= done_d;
         start_q <= start_d;
         end_q   <= end_d;
         xz_q    <= xz_d;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ptr_nxt   = ptr;
      g_nxt     = g;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = START;
               g_nxt     = pick_idx;
               cnt_nxt   = (len_sel == '0) ? CNT_W'(1) : len_sel;
            end
         end
         START: state_nxt = OPEN;
         OPEN: begin
            if (cnt <= CNT_W'(1)) state_nxt = END;
            else                  cnt_nxt   = cnt - CNT_W'(1);
         end
         END: begin
            ptr_nxt = (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
            if (MIN_GAP > 0) begin
               state_nxt = GAP;
               cnt_nxt   = CNT_W'(MIN_GAP);
            end else begin
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (cnt <= CNT_W'(1)) state_nxt = IDLE;
            else                  cnt_nxt   = cnt - CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered: each pulse appears the cycle after its state.
   always_comb begin
      grant_d = grant_q;
      done_d  = '0;
      start_d = (state == START);
      end_d   = (state == END);
      xz_d    = 1'b0;
      case (state)
         IDLE: begin
            xz_d    = in_xz;
            grant_d = accept ? NUM_REQ'(onehot(32'(pick_idx))) : '0;
         end
         END:     done_d  = NUM_REQ'(onehot(32'(g)));
         GAP:     grant_d = '0;
         default: ;
      endcase
   end

   assign bus.grant       = grant_q;
   assign bus.done        = done_q;
   assign bus.start_event = start_q;
   assign bus.end_event   = end_q;
   assign bus.xz_err      = xz_q;
   assign bus.busy        = (state != IDLE);
   assign bus.test_expr   = (grant_q != '0) ? bus.req_expr[g*WIDTH +: WIDTH] : '0;
endmodule

// File: tb/tb_ovl_win_chk_arbiter.sv
// Directed bench for ovl_win_chk_arbiter (NUM_REQ=4, WIDTH=4, CNT_W=8, MIN_GAP=1).
module tb_ovl_win_chk_arbiter;
   logic clock;
   logic reset;
   logic probe;
   int   checks = 0;
   int   errors = 0;

   ovl_win_chk_arbiter_if #(.NUM_REQ(4), .WIDTH(4), .CNT_W(8)) bus ();

   ovl_win_chk_arbiter #(.NUM_REQ(4), .WIDTH(4), .CNT_W(8), .MIN_GAP(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Called in the cycle the grant first shows; returns in the end_event cycle.
   task automatic window_check(input int idx, input int len, input int expr);
      chk("grant_first", 32'(bus.grant), 1 << idx);
      chk("expr_first", 32'(bus.test_expr), expr);
      chk("start_early", 32'(bus.start_event), 0);
      step();
      chk("start_pulse", 32'(bus.start_event), 1);
      chk("grant_start", 32'(bus.grant), 1 << idx);
      chk("end_with_start", 32'(bus.end_event), 0);
      for (int k = 0; k < len; k++) begin
         step();
         chk("start_open", 32'(bus.start_event), 0);
         chk("end_open", 32'(bus.end_event), 0);
         chk("expr_open", 32'(bus.test_expr), expr);
      end
      step();
      chk("end_pulse", 32'(bus.end_event), 1);
      chk("done_pulse", 32'(bus.done), 1 << idx);
      chk("grant_end", 32'(bus.grant), 1 << idx);
      chk("start_at_end", 32'(bus.start_event), 0);
   endtask

   task automatic gap_then_grant();
      step();
      chk("gap_grant", 32'(bus.grant), 0);
      chk("gap_expr", 32'(bus.test_expr), 0);
      chk("gap_busy", 32'(bus.busy), 0);
      step();
   endtask

   initial begin
      reset        = 1'b1;
      bus.enable   = 1'b0;
      bus.req      = '0;
      bus.win_len  = '0;
      bus.req_expr = '0;
      step();
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_start", 32'(bus.start_event), 0);
      chk("rst_end", 32'(bus.end_event), 0);
      chk("rst_expr", 32'(bus.test_expr), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_xz", 32'(bus.xz_err), 0);
      reset = 1'b0;

      // Single requester 1, length 3, expression 5.
      bus.enable            = 1'b1;
      bus.req               = 4'b0010;
      bus.win_len[8 +: 8]   = 8'd3;
      bus.req_expr[4 +: 4]  = 4'h5;
      step();
      chk("t1_busy", 32'(bus.busy), 1);
      window_check(1, 3, 5);
      bus.req = '0;
      step();
      chk("t1_grant_off", 32'(bus.grant), 0);
      chk("t1_end_off", 32'(bus.end_event), 0);
      chk("t1_done_off", 32'(bus.done), 0);
      step();
      chk("t1_idle_busy", 32'(bus.busy), 0);

      // Reset in IDLE returns the pointer to 0.
      reset = 1'b1;
      step();
      reset = 1'b0;

      // All four requesting, length 2: order 0,1,2,3,0.
      for (int i = 0; i < 4; i++) begin
         bus.win_len[i*8 +: 8]  = 8'd2;
         bus.req_expr[i*4 +: 4] = 4'(8 + i);
      end
      bus.req = 4'b1111;
      step();
      window_check(0, 2, 'h8);
      gap_then_grant();
      window_check(1, 2, 'h9);
      gap_then_grant();
      window_check(2, 2, 'hA);
      gap_then_grant();
      window_check(3, 2, 'hB);
      gap_then_grant();
      window_check(0, 2, 'h8);
      bus.req = '0;
      step();
      chk("t2_grant_off", 32'(bus.grant), 0);

      // Owner 2 changes its expression inside the window.
      bus.req               = 4'b0100;
      bus.win_len[16 +: 8]  = 8'd3;
      bus.req_expr[8 +: 4]  = 4'h1;
      step();
      chk("t3_grant", 32'(bus.grant), 4);
      chk("t3_expr1", 32'(bus.test_expr), 1);
      step();
      chk("t3_start", 32'(bus.start_event), 1);
      step();
      bus.req_expr[8 +: 4] = 4'h2;
      #1;
      chk("t3_expr2", 32'(bus.test_expr), 2);
      step();
      chk("t3_end_a", 32'(bus.end_event), 0);
      step();
      chk("t3_end_b", 32'(bus.end_event), 0);
      step();
      chk("t3_end", 32'(bus.end_event), 1);
      chk("t3_done", 32'(bus.done), 4);
      chk("t3_expr_end", 32'(bus.test_expr), 2);
      bus.req = '0;
      step();
      chk("t3_grant_off", 32'(bus.grant), 0);

      // Pointer now 3; zero length; req/win_len changes after grant are ignored.
      bus.req              = 4'b1001;
      bus.win_len[24 +: 8] = 8'd0;
      step();
      bus.req              = '0;
      bus.win_len[24 +: 8] = 8'd5;
      window_check(3, 1, 'hB);
      step();
      chk("t4_grant_off", 32'(bus.grant), 0);

      // Reset two cycles into OPEN aborts the window at once.
      bus.req             = 4'b0110;
      bus.win_len[8 +: 8] = 8'd4;
      step();
      chk("t5_grant", 32'(bus.grant), 2);
      step();
      chk("t5_start", 32'(bus.start_event), 1);
      step();
      step();
      reset = 1'b1;
      #1;
      chk("t5_abort_grant", 32'(bus.grant), 0);
      chk("t5_abort_start", 32'(bus.start_event), 0);
      chk("t5_abort_end", 32'(bus.end_event), 0);
      chk("t5_abort_busy", 32'(bus.busy), 0);
      chk("t5_abort_expr", 32'(bus.test_expr), 0);
      step();
      chk("t5_no_end", 32'(bus.end_event), 0);
      reset               = 1'b0;
      bus.req             = 4'b0011;
      bus.win_len[0 +: 8] = 8'd2;
      step();
      bus.enable = 1'b0;
      window_check(0, 2, 'h8);
      step();
      chk("t5_grant_off", 32'(bus.grant), 0);

      // enable low with requests pending: no grant.
      step();
      step();
      chk("t6_en_grant", 32'(bus.grant), 0);
      chk("t6_en_busy", 32'(bus.busy), 0);

      // Unknown request bits only exist on four-state simulators.
      probe = 1'bx;
      if ($isunknown(probe)) begin
         bus.enable = 1'b1;
         bus.req    = 4'b00x1;
         step();
         chk("t6_xz_pulse", 32'(bus.xz_err), 1);
         chk("t6_xz_grant", 32'(bus.grant), 0);
         bus.req = '0;
         step();
         chk("t6_xz_clear", 32'(bus.xz_err), 0);
         chk("t6_xz_busy", 32'(bus.busy), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
